// File: rtl/ps2_key_frontend.sv
// PS/2 keyboard front end: deframes scan codes, strips E0/F0 prefixes and
// tracks the held make code plus the mode chosen by the function keys.
module ps2_key_frontend #(
    parameter int          FILTER_LEN = 8,
    parameter int          TIMEOUT    = 100000,
    parameter logic [7:0]  KEY_MANUAL = 8'h05,
    parameter logic [7:0]  KEY_PLAY   = 8'h06,
    parameter logic [7:0]  KEY_REC    = 8'h04
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] data,
    output logic [1:0] released,
    output logic       key_valid,
    output logic       frame_err
);

    localparam int FW = $clog2(FILTER_LEN + 1);
    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

    logic [1:0]    clk_sync;
    logic [1:0]    data_sync;
    logic [FW-1:0] filt_cnt;
    logic          filt_clk;
    logic          fall;
    state_t        state;
    state_t        state_next;
    logic [2:0]    bit_cnt;
    logic [7:0]    shift;
    logic          par_bit;
    logic [TW-1:0] tmo_cnt;
    logic          timeout_hit;
    logic          byte_done;
    logic          err_det;
    logic [7:0]    byte_q;
    logic          ext;
    logic          brk;

    // The lines idle high, so the synchronizers and filter start high to avoid a false edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            clk_sync  <= 2'b11;
            data_sync <= 2'b11;
        end else begin
            clk_sync  <= {clk_sync[0], ps2_clk};
            data_sync <= {data_sync[0], ps2_data};
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            filt_cnt <= '0;
            filt_clk <= 1'b1;
            fall     <= 1'b0;
        end else begin
            fall <= 1'b0;
            if (clk_sync[1] == filt_clk) begin
                filt_cnt <= '0;
            end else if (filt_cnt == FW'(FILTER_LEN - 1)) begin
                filt_clk <= clk_sync[1];
                filt_cnt <= '0;
                fall     <= filt_clk;
            end else begin
                filt_cnt <= filt_cnt + 1'b1;
            end
        end
    end

    assign timeout_hit = (state != IDLE) && !fall && (tmo_cnt == TW'(TIMEOUT - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tmo_cnt <= '0;
        end else if (fall || state == IDLE || timeout_hit) begin
            tmo_cnt <= '0;
        end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
        end
    end

    always_comb begin
        state_next = state;
        if (timeout_hit) begin
            state_next = IDLE;
        end else if (fall) begin
            case (state)
                IDLE:    if (!data_sync[1]) state_next = DATA;
                DATA:    if (bit_cnt == 3'd7) state_next = PARITY;
                PARITY:  state_next = STOP;
                STOP:    state_next = IDLE;
                default: state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            bit_cnt   <= '0;
            shift     <= '0;
            par_bit   <= 1'b0;
            byte_done <= 1'b0;
            err_det   <= 1'b0;
            byte_q    <= '0;
        end else begin
            state     <= state_next;
            byte_done <= 1'b0;
            err_det   <= 1'b0;
            if (timeout_hit) begin
                err_det <= 1'b1;
            end else if (fall) begin
                case (state)
                    IDLE:   bit_cnt <= '0;
                    DATA: begin
                        shift[bit_cnt] <= data_sync[1];
                        bit_cnt        <= bit_cnt + 1'b1;
                    end
                    PARITY: par_bit <= data_sync[1];
                    STOP: begin
                        if (data_sync[1] && (^{shift, par_bit})) begin
                            byte_done <= 1'b1;
                            byte_q    <= shift;
                        end else begin
                            err_det <= 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    // Error and byte results share one output stage, so the two pulses can never coincide.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data      <= '0;
            released  <= '0;
            key_valid <= 1'b0;
            frame_err <= 1'b0;
            ext       <= 1'b0;
            brk       <= 1'b0;
        end else begin
            key_valid <= 1'b0;
            frame_err <= 1'b0;
            if (err_det) begin
                frame_err <= 1'b1;
                ext       <= 1'b0;
                brk       <= 1'b0;
            end else if (byte_done) begin
                key_valid <= 1'b1;
                if (byte_q == 8'hE0) begin
                    if (!ext) ext <= 1'b1;
                end else if (byte_q == 8'hF0) begin
                    brk <= 1'b1;
                end else begin
                    ext <= 1'b0;
                    brk <= 1'b0;
                    if (brk) begin
                        if (byte_q == data) data <= 8'h00;
                    end else if (byte_q == KEY_MANUAL) begin
                        released <= 2'd0;
                    end else if (byte_q == KEY_PLAY) begin
                        released <= 2'd1;
                    end else if (byte_q == KEY_REC) begin
                        released <= 2'd2;
                    end else begin
                        data <= byte_q;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_ps2_key_frontend.sv
// Self-checking bench for ps2_key_frontend: directed PS/2 frames against a
// scan-code-level model, with a per-cycle compare process and literal pins.
`timescale 1ns/1ps
module tb_ps2_key_frontend;

    localparam int FILTER_LEN = 8;
    localparam int TIMEOUT    = 2000;
    localparam int HALF       = 40;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       ps2_clk = 1'b1;
    logic       ps2_data = 1'b1;
    logic [7:0] data;
    logic [1:0] released;
    logic       key_valid;
    logic       frame_err;

    int checks = 0;
    int errors = 0;
    int kv_seen = 0;
    int fe_seen = 0;
    bit steady = 1'b0;

    logic [7:0] exp_data = 8'h00;
    logic [1:0] exp_mode = 2'd0;
    bit         mdl_brk = 1'b0;

    always #5 clk = ~clk;

    ps2_key_frontend #(
        .FILTER_LEN(FILTER_LEN),
        .TIMEOUT   (TIMEOUT),
        .KEY_MANUAL(8'h05),
        .KEY_PLAY  (8'h06),
        .KEY_REC   (8'h04)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .ps2_clk  (ps2_clk),
        .ps2_data (ps2_data),
        .data     (data),
        .released (released),
        .key_valid(key_valid),
        .frame_err(frame_err)
    );

    task automatic checkOutput(input string name, input logic [7:0] actual, input logic [7:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %02h expected %02h at %0t", name, actual, expected, $time);
        end
    endtask

    // Scan-code rules: prefixes set flags, breaks release the matching key, mode keys pick the mode.
    task automatic modelByte(input logic [7:0] b);
        if (b == 8'hF0) begin
            mdl_brk = 1'b1;
        end else if (b != 8'hE0) begin
            if (mdl_brk) begin
                if (b == exp_data) exp_data = 8'h00;
            end else begin
                case (b)
                    8'h05:   exp_mode = 2'd0;
                    8'h06:   exp_mode = 2'd1;
                    8'h04:   exp_mode = 2'd2;
                    default: exp_data = b;
                endcase
            end
            mdl_brk = 1'b0;
        end
    endtask

    always @(posedge clk) begin
        #2;
        if (!reset) begin
            if (key_valid) kv_seen++;
            if (frame_err) fe_seen++;
            if (key_valid || frame_err)
                checkOutput("pulse_exclusive", 8'(key_valid & frame_err), 8'h00);
            if (steady) begin
                checkOutput("data_track", data, exp_data);
                checkOutput("mode_track", 8'(released), 8'(exp_mode));
            end
        end
    end

    task automatic applyStimulus(input logic [7:0] code, input int nbits, input bit bad_par);
        logic [10:0] frame;
        logic        par;
        par   = bad_par ? (^code) : ~(^code);
        frame = {1'b1, par, code, 1'b0};
        for (int i = 0; i < nbits; i++) begin
            if (i == 10) steady = 1'b0;
            @(negedge clk);
            ps2_data = frame[i];
            repeat (HALF) @(negedge clk);
            ps2_clk = 1'b0;
            repeat (HALF) @(negedge clk);
            ps2_clk = 1'b1;
        end
        ps2_data = 1'b1;
        repeat (HALF) @(negedge clk);
    endtask

    task automatic sendFrame(input logic [7:0] code, input bit bad_par);
        int kv0;
        int fe0;
        kv0 = kv_seen;
        fe0 = fe_seen;
        applyStimulus(code, 11, bad_par);
        if (bad_par) mdl_brk = 1'b0;
        else modelByte(code);
        steady = 1'b1;
        checkOutput("key_valid_count", 8'(kv_seen - kv0), bad_par ? 8'd0 : 8'd1);
        checkOutput("frame_err_count", 8'(fe_seen - fe0), bad_par ? 8'd1 : 8'd0);
    endtask

    initial begin
        int kv0;
        int fe0;
        repeat (3) @(negedge clk);
        checkOutput("reset_data", data, 8'h00);
        checkOutput("reset_mode", 8'(released), 8'h00);
        checkOutput("reset_kv", 8'(key_valid), 8'h00);
        checkOutput("reset_fe", 8'(frame_err), 8'h00);
        reset = 1'b0;
        repeat (20) @(negedge clk);
        steady = 1'b1;

        sendFrame(8'h1D, 1'b0);
        checkOutput("pin_make_1D", data, 8'h1D);
        sendFrame(8'hF0, 1'b0);
        checkOutput("pin_f0_holds", data, 8'h1D);
        sendFrame(8'h1D, 1'b0);
        checkOutput("pin_break_1D", data, 8'h00);

        sendFrame(8'hE0, 1'b0);
        sendFrame(8'h75, 1'b0);
        checkOutput("pin_ext_make", data, 8'h75);
        sendFrame(8'hE0, 1'b0);
        sendFrame(8'hF0, 1'b0);
        sendFrame(8'h75, 1'b0);
        checkOutput("pin_ext_break", data, 8'h00);
        checkOutput("pin_mode_manual", 8'(released), 8'h00);

        sendFrame(8'h2A, 1'b0);
        sendFrame(8'h06, 1'b0);
        checkOutput("pin_mode_play", 8'(released), 8'h01);
        checkOutput("pin_data_kept", data, 8'h2A);
        sendFrame(8'hF0, 1'b0);
        sendFrame(8'h06, 1'b0);
        checkOutput("pin_play_break", 8'(released), 8'h01);
        sendFrame(8'h04, 1'b0);
        checkOutput("pin_mode_rec", 8'(released), 8'h02);
        sendFrame(8'hF0, 1'b0);
        sendFrame(8'h04, 1'b0);
        sendFrame(8'h05, 1'b0);
        checkOutput("pin_mode_back", 8'(released), 8'h00);
        sendFrame(8'h2A, 1'b0);
        checkOutput("pin_typematic", data, 8'h2A);

        sendFrame(8'h23, 1'b1);
        checkOutput("pin_bad_parity", data, 8'h2A);
        sendFrame(8'h23, 1'b0);
        checkOutput("pin_after_err", data, 8'h23);

        kv0 = kv_seen;
        fe0 = fe_seen;
        applyStimulus(8'h55, 5, 1'b0);
        repeat (TIMEOUT + 20) @(negedge clk);
        mdl_brk = 1'b0;
        checkOutput("timeout_fe", 8'(fe_seen - fe0), 8'd1);
        checkOutput("timeout_kv", 8'(kv_seen - kv0), 8'd0);
        sendFrame(8'h1B, 1'b0);
        checkOutput("pin_after_tmo", data, 8'h1B);

        sendFrame(8'h1C, 1'b0);
        sendFrame(8'h23, 1'b0);
        checkOutput("pin_last_wins", data, 8'h23);
        sendFrame(8'hF0, 1'b0);
        sendFrame(8'h1C, 1'b0);
        checkOutput("pin_old_break", data, 8'h23);
        sendFrame(8'h06, 1'b0);

        steady = 1'b0;
        applyStimulus(8'h31, 4, 1'b0);
        ps2_data = 1'b1;
        repeat (HALF) @(negedge clk);
        ps2_clk = 1'b0;
        repeat (HALF / 2) @(negedge clk);
        reset = 1'b1;
        #1;
        checkOutput("midreset_data", data, 8'h00);
        checkOutput("midreset_mode", 8'(released), 8'h00);
        checkOutput("midreset_kv", 8'(key_valid), 8'h00);
        checkOutput("midreset_fe", 8'(frame_err), 8'h00);
        exp_data = 8'h00;
        exp_mode = 2'd0;
        mdl_brk  = 1'b0;
        ps2_clk  = 1'b1;
        repeat (20) @(negedge clk);
        reset = 1'b0;
        repeat (50) @(negedge clk);
        steady = 1'b1;
        sendFrame(8'h31, 1'b0);
        checkOutput("pin_after_reset", data, 8'h31);

        repeat (20) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
